// File: rtl/multicycle_control_if.sv
// Control/datapath bundle between the multicycle control FSM (master) and the
// datapath (slave): opcode/flags in, PC and datapath strobes/selects out.
interface multicycle_control_if #(
  parameter int STATE_WIDTH  = 4,
  parameter int OPCODE_WIDTH = 6
);
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    zero;
  logic                    mem_ready;
  logic                    pc_en;
  logic                    pc_write;
  logic                    branch;
  logic [1:0]              pc_src;
  logic                    iord;
  logic                    mem_write;
  logic                    ir_write;
  logic                    reg_dst;
  logic                    mem_to_reg;
  logic                    reg_write;
  logic                    alu_src_a;
  logic [1:0]              alu_src_b;
  logic [1:0]              alu_op;
  logic                    illegal_op;
  logic [STATE_WIDTH-1:0]  state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, pc_write, branch, pc_src, iord, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, pc_write, branch, pc_src, iord, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           illegal_op, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle MIPS core; Moore outputs except pc_en.
// Optional MULTICYCLE_CONTROL_MEM_WAIT_EN stalls FETCH/MEMRD/MEMWR on mem_ready.
//
// state  | meaning
// FETCH  | read instruction, PC <= PC+4
// DECODE | register read, branch target into ALUOut
// MEMADR | lw/sw address calculation
// MEMRD  | lw memory read
// MEMWB  | lw writeback from MDR
// MEMWR  | sw memory write
// EXEC   | R-type ALU operation
// ALUWB  | R-type writeback to rd
// BEQ    | compare, conditional PC load
// ADDIEX | addi ALU operation
// ADDIWB | addi writeback to rt
// JUMP   | PC <= jump target
module multicycle_control_fsm #(
  parameter int STATE_WIDTH  = 4,
  parameter int OPCODE_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  typedef enum logic [STATE_WIDTH-1:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BEQ    = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'b101011;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       mem_ok;
  logic       pc_write, branch, iord, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] pc_src, alu_src_b, alu_op;

`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // In reset the decode is forced to FETCH so selects are defined; strobes are masked below.
  always_comb begin
    state_d    = FETCH;
    illegal_d  = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    pc_src     = 2'b00;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (rst ? FETCH : state_q)
      FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ok;
        pc_write  = mem_ok;
        state_d   = mem_ok ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BEQ;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      illegal_d = 1'b1;
        endcase
      end
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (state_q == ADDIEX) state_d = ADDIWB;
        else                   state_d = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ok ? MEMWB : MEMRD;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = mem_ok;
        state_d   = mem_ok ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      ADDIWB: reg_write = 1'b1;
      BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    if (rst) begin
      pc_write  = 1'b0;
      branch    = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign bus.pc_en      = pc_write | (branch & bus.zero);
  assign bus.pc_write   = pc_write;
  assign bus.branch     = branch;
  assign bus.pc_src     = pc_src;
  assign bus.iord       = iord;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_write  = reg_write;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.illegal_op = illegal_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed vector table,
// randomized instruction stream against a per-instruction path model.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_if #(.STATE_WIDTH(4), .OPCODE_WIDTH(6)) bus ();
  multicycle_control_fsm #(.STATE_WIDTH(4), .OPCODE_WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic exp_ill = 1'b0;

  typedef struct packed {
    logic       pc_write, branch;
    logic [1:0] pc_src;
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
  } ctl_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       zero;
    int         st;
    logic       pc_en, pc_write, reg_write, mem_write, ill;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ctl_t exp_ctl(input int st);
    ctl_t c = '0;
    case (st)
      0:  begin c.pc_write = 1; c.ir_write = 1; c.alu_src_b = 2'b01; end
      1:  c.alu_src_b = 2'b11;
      2, 9: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  c.iord = 1;
      4:  begin c.mem_to_reg = 1; c.reg_write = 1; end
      5:  begin c.iord = 1; c.mem_write = 1; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_dst = 1; c.reg_write = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.branch = 1; end
      10: c.reg_write = 1;
      11: begin c.pc_src = 2'b10; c.pc_write = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic ctl_t get_ctl();
    ctl_t c;
    c.pc_write = bus.pc_write;   c.branch = bus.branch;         c.pc_src = bus.pc_src;
    c.iord = bus.iord;           c.mem_write = bus.mem_write;   c.ir_write = bus.ir_write;
    c.reg_dst = bus.reg_dst;     c.mem_to_reg = bus.mem_to_reg; c.reg_write = bus.reg_write;
    c.alu_src_a = bus.alu_src_a; c.alu_src_b = bus.alu_src_b;   c.alu_op = bus.alu_op;
    return c;
  endfunction

  function automatic bit is_illegal(input logic [5:0] op);
    return !(op inside {6'b000000, 6'b000010, 6'b000100, 6'b001000, 6'b100011, 6'b101011});
  endfunction

  // Sequence of states an instruction visits, starting at FETCH.
  function automatic void inst_path(input logic [5:0] op, output int p[$]);
    p = {0, 1};
    case (op)
      6'b100011: p = {p, 2, 3, 4};
      6'b101011: p = {p, 2, 5};
      6'b000000: p = {p, 6, 7};
      6'b001000: p = {p, 9, 10};
      6'b000100: p = {p, 8};
      6'b000010: p = {p, 11};
      default: ;
    endcase
  endfunction

  task automatic run_cycle(input logic r, input logic [5:0] op, input logic z,
                           input logic mr, input int exp_st);
    ctl_t e;
    logic memok;
    @(negedge clk);
    rst = r; bus.opcode = op; bus.zero = z; bus.mem_ready = mr;
    #1;
`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
    memok = mr;
`else
    memok = 1'b1;
`endif
    e = exp_ctl(r ? 0 : exp_st);
    if (!memok) begin e.pc_write = 0; e.ir_write = 0; e.mem_write = 0; end
    if (r) begin e.pc_write = 0; e.branch = 0; e.ir_write = 0; e.reg_write = 0; e.mem_write = 0; end
    chk("state", 32'(bus.state), 32'(exp_st));
    chk("ctl", 32'(get_ctl()), 32'(e));
    chk("pc_en", 32'(bus.pc_en), 32'(e.pc_write | (e.branch & z)));
    chk("illegal_op", 32'(bus.illegal_op), 32'(exp_ill));
    exp_ill = !r && exp_st == 1 && is_illegal(op);
  endtask

  function automatic logic rnd_ready();
`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
    return 1'b1;
`else
    return 1'($urandom);
`endif
  endfunction

  vec_t vt[$];

  initial begin
    int p[$];
    logic [5:0] op;
    logic r;
    rst = 1'b1; bus.opcode = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    //        rst  op         z  st  pe pw rw mw ill
    vt.push_back('{1, 6'h00,    0, 0,  0, 0, 0, 0, 0});
    vt.push_back('{0, 6'b100011, 0, 0,  1, 1, 0, 0, 0});
    vt.push_back('{0, 6'b100011, 0, 1,  0, 0, 0, 0, 0});
    vt.push_back('{0, 6'b100011, 0, 2,  0, 0, 0, 0, 0});
    vt.push_back('{0, 6'b100011, 0, 3,  0, 0, 0, 0, 0});
    vt.push_back('{0, 6'b100011, 0, 4,  0, 0, 1, 0, 0});
    vt.push_back('{0, 6'b000100, 0, 0,  1, 1, 0, 0, 0});
    vt.push_back('{0, 6'b000100, 1, 1,  0, 0, 0, 0, 0});
    vt.push_back('{0, 6'b000100, 1, 8,  1, 0, 0, 0, 0});
    vt.push_back('{0, 6'b000100, 0, 0,  1, 1, 0, 0, 0});
    vt.push_back('{0, 6'b000100, 0, 1,  0, 0, 0, 0, 0});
    vt.push_back('{0, 6'b000100, 0, 8,  0, 0, 0, 0, 0});
    vt.push_back('{0, 6'b111111, 0, 0,  1, 1, 0, 0, 0});
    vt.push_back('{0, 6'b111111, 0, 1,  0, 0, 0, 0, 0});
    vt.push_back('{0, 6'b101011, 0, 0,  1, 1, 0, 0, 1});
    vt.push_back('{0, 6'b101011, 0, 1,  0, 0, 0, 0, 0});
    vt.push_back('{1, 6'b101011, 1, 2,  0, 0, 0, 0, 0});
    vt.push_back('{0, 6'b101011, 0, 0,  1, 1, 0, 0, 0});
    vt.push_back('{0, 6'b101011, 0, 1,  0, 0, 0, 0, 0});
    vt.push_back('{0, 6'b101011, 0, 2,  0, 0, 0, 0, 0});
    vt.push_back('{0, 6'b101011, 0, 5,  0, 0, 0, 1, 0});
    vt.push_back('{0, 6'b000000, 0, 0,  1, 1, 0, 0, 0});

    foreach (vt[i]) begin
      @(negedge clk);
      rst = vt[i].rst; bus.opcode = vt[i].op; bus.zero = vt[i].zero; bus.mem_ready = rnd_ready();
      #1;
      chk($sformatf("vec%0d.state", i), 32'(bus.state), 32'(vt[i].st));
      chk($sformatf("vec%0d.pc_en", i), 32'(bus.pc_en), 32'(vt[i].pc_en));
      chk($sformatf("vec%0d.pc_write", i), 32'(bus.pc_write), 32'(vt[i].pc_write));
      chk($sformatf("vec%0d.reg_write", i), 32'(bus.reg_write), 32'(vt[i].reg_write));
      chk($sformatf("vec%0d.mem_write", i), 32'(bus.mem_write), 32'(vt[i].mem_write));
      chk($sformatf("vec%0d.illegal_op", i), 32'(bus.illegal_op), 32'(vt[i].ill));
    end

    // Last vector left the FSM heading into DECODE; reset from there.
    exp_ill = 1'b0;
    run_cycle(1'b1, 6'h00, 1'b0, rnd_ready(), 1);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 6))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        default: op = 6'($urandom);
      endcase
      inst_path(op, p);
      foreach (p[i]) begin
        r = ($urandom_range(0, 39) == 0);
        run_cycle(r, op, 1'($urandom), rnd_ready(), p[i]);
        if (r) break;
      end
    end

`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
    run_cycle(1'b1, 6'b101011, 1'b0, 1'b1, 0);
    repeat (3) run_cycle(1'b0, 6'b101011, 1'b0, 1'b0, 0);
    run_cycle(1'b0, 6'b101011, 1'b0, 1'b1, 0);
    run_cycle(1'b0, 6'b101011, 1'b0, 1'b0, 1);
    run_cycle(1'b0, 6'b101011, 1'b0, 1'b0, 2);
    repeat (2) run_cycle(1'b0, 6'b101011, 1'b0, 1'b0, 5);
    run_cycle(1'b0, 6'b101011, 1'b0, 1'b1, 5);
    run_cycle(1'b0, 6'b100011, 1'b0, 1'b1, 0);
    run_cycle(1'b0, 6'b100011, 1'b0, 1'b0, 1);
    run_cycle(1'b0, 6'b100011, 1'b0, 1'b0, 2);
    run_cycle(1'b0, 6'b100011, 1'b0, 1'b0, 3);
    run_cycle(1'b1, 6'b100011, 1'b0, 1'b0, 3);
    run_cycle(1'b0, 6'b100011, 1'b0, 1'b1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control unit of the multicycle MIPS core; sits directly upstream of the program counter register.
- Sequences every instruction through fetch/decode/execute/memory/writeback states.
- Drives the PC load enable (pc_en), the PC source select and all datapath strobes and selects.
- Outputs are Moore-decoded from the state register, except pc_en, which also depends on the ALU zero flag.

Parameters:
- STATE_WIDTH, 4, width of the state register and of the debug state output.
- OPCODE_WIDTH, 6, width of the instruction opcode field.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- opcode  input  OPCODE_WIDTH  instruction[31:26], taken from the instruction register
- zero  input  1  ALU zero flag, valid in BEQ state
- mem_ready  input  1  memory access complete (used only with MEM_WAIT_EN)
- pc_en  output  1  PC load enable = pc_write | (branch & zero)
- pc_write  output  1  unconditional PC write
- branch  output  1  conditional branch strobe
- pc_src  output  2  next-PC select: 00 ALU result, 01 ALUOut register, 10 jump target
- iord  output  1  memory address select: 0 PC, 1 ALUOut
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load
- reg_dst  output  1  write register select: 0 rt, 1 rd
- mem_to_reg  output  1  writeback data select: 0 ALUOut, 1 MDR
- reg_write  output  1  register file write strobe
- alu_src_a  output  1  ALU A select: 0 PC, 1 register A
- alu_src_b  output  2  ALU B select: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate << 2
- alu_op  output  2  ALU op class: 00 add, 01 sub, 10 decode funct
- illegal_op  output  1  one-cycle registered pulse on an unsupported opcode
- state  output  STATE_WIDTH  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable and go to FETCH on the next edge.
- Reset (synchronous, active-high):
  - state <= FETCH; illegal_op <= 0.
  - While rst=1, pc_write, pc_en, branch, ir_write, reg_write and mem_write are forced to 0.
  - All other outputs show their FETCH decode.
  - rst asserted mid-instruction abandons the instruction; no strobe fires in the reset cycle.
- Transitions, one state per clock unless stated:
  - FETCH->DECODE.
  - DECODE->MEMADR for lw (100011) and sw (101011).
  - DECODE->EXEC for R-type (000000).
  - DECODE->BEQ for beq (000100).
  - DECODE->ADDIEX for addi (001000).
  - DECODE->JUMP for j (000010).
  - DECODE->FETCH for any other opcode; illegal_op=1 in the following cycle.
  - MEMADR->MEMRD for lw, ->MEMWR for sw.
  - MEMRD->MEMWB.
  - EXEC->ALUWB; ADDIEX->ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BEQ and JUMP all ->FETCH.
- Output decode (unlisted outputs are 0):
  - FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=1, pc_write=1.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
  - MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMRD: iord=1.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
  - MEMWR: iord=1, mem_write=1.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1.
  - BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1.
  - JUMP: pc_src=10, pc_write=1.
- pc_en is combinational in zero. A beq is taken when pc_en=1 in the BEQ cycle, and not taken when zero=0.
- CPI:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
  - illegal opcode: 2
- opcode is sampled only in DECODE and MEMADR; it must be held stable by the instruction register, which ir_write loads only in FETCH.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_MEM_WAIT_EN.
- Defined:
  - FETCH, MEMRD and MEMWR hold their state, with all outputs held, until mem_ready=1; the transition happens on the edge where mem_ready=1.
  - pc_write and ir_write in FETCH, and mem_write in MEMWR, assert only in the cycle where mem_ready=1, so each stalled access produces exactly one strobe.
  - rst overrides any wait.
- Undefined: mem_ready is ignored and every memory state lasts exactly one cycle.

Test Plan:
- Reset: rst=1 for 2 cycles, then release -> state=0, pc_write=0 and pc_en=0 during reset; the first cycle after release shows pc_write=1, ir_write=1, alu_src_b=01.
- lw sequence: opcode=100011 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; pc_en=1 only in state 0.
- beq taken vs not taken: opcode=000100 with zero=1 in state 8 -> pc_en=1, pc_src=01; repeat with zero=0 -> pc_en=0; both return to FETCH after 3 cycles.
- Illegal opcode: opcode=111111 -> states 0,1,0; illegal_op pulses high for exactly one cycle; reg_write and mem_write never assert.
- Reset mid-instruction: opcode=101011 with rst=1 in MEMADR -> next state 0; mem_write is never asserted.
- With MULTICYCLE_CONTROL_MEM_WAIT_EN: mem_ready low for 3 cycles in FETCH -> state stays 0 for 4 cycles; pc_write=1 only in the cycle where mem_ready=1.
